bypass_scoreboard: RTL

- Parametrised successor to the single-port ME/WB bypass mux.
- Forwards results to NUM_RPORTS decode read ports from NUM_FWD pipeline stages, in priority order.
- Adds a per-register countdown scoreboard for multi-cycle producers (load, mul/div). It raises a decode stall while a source operand is still in flight.
- Sits between the regfile read and the ID/EX register. It drives the pipeline stall and holds a saturating stall-cycle counter for performance debug.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/bypass_fwd_sel.sv | 31 +++
 rtl/bypass_scoreboard.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: register-file geometry defaults and producer latency codes.
package cpu_pkg;

    localparam int unsigned CPU_ADDR_W = 5;
    localparam int unsigned CPU_DATA_W = 32;
    localparam int unsigned REG_ZERO   = 0;

    localparam int unsigned LAT_ALU  = 0;
    localparam int unsigned LAT_LOAD = 2;
    localparam int unsigned LAT_MUL  = 3;

endpackage

// File: rtl/bypass_fwd_sel.sv
// Single-port priority forwarding selector: the youngest matching stage wins and
// register zero is never forwarded.
module bypass_fwd_sel
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned ADDR_W  = CPU_ADDR_W,
    parameter int unsigned DATA_W  = CPU_DATA_W
) (
    input  logic [ADDR_W-1:0]         raddr,
    input  logic [DATA_W-1:0]         rdata_old,
    input  logic [NUM_FWD-1:0]        fwd_wen,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    output logic [DATA_W-1:0]         rdata
);

    always_comb begin
        rdata = rdata_old;
        // Walk oldest to youngest so the lowest matching index is written last.
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_wen[k] && fwd_waddr[k*ADDR_W +: ADDR_W] == raddr) begin
                rdata = fwd_wdata[k*DATA_W +: DATA_W];
            end
        end
        if (raddr == ADDR_W'(REG_ZERO)) begin
            rdata = rdata_old;
        end
    end

endmodule

// File: rtl/bypass_scoreboard.sv
// Multi-port operand bypass with a per-register latency scoreboard that stalls decode
// while a multi-cycle producer is in flight, plus a saturating stall-cycle counter.
module bypass_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned DATA_W     = CPU_DATA_W,
    parameter int unsigned ADDR_W     = CPU_ADDR_W,
    parameter int unsigned LAT_W      = 3,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         id_valid,
    input  logic [NUM_RPORTS*ADDR_W-1:0] id_raddr,
    input  logic [NUM_RPORTS*DATA_W-1:0] id_rdata_old,
    input  logic                         id_wen,
    input  logic [ADDR_W-1:0]            id_waddr,
    input  logic [LAT_W-1:0]             id_lat,
    input  logic                         pipe_hold,
    input  logic                         flush,
    input  logic [NUM_FWD-1:0]           fwd_wen,
    input  logic [NUM_FWD*ADDR_W-1:0]    fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0]    fwd_wdata,
    output logic [NUM_RPORTS*DATA_W-1:0] id_rdata,
    output logic                         stall,
    output logic [CNT_W-1:0]             stall_cycles
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [LAT_W-1:0]    cnt_q [NUM_REGS-1:1];
    logic [LAT_W-1:0]    cnt_d [NUM_REGS-1:1];
    logic [NUM_REGS-1:0] busy;
    logic                issue;
    logic [CNT_W-1:0]    stall_cycles_q;

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
        bypass_fwd_sel #(
            .NUM_FWD (NUM_FWD),
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W)
        ) u_fwd_sel (
            .raddr     (id_raddr[p*ADDR_W +: ADDR_W]),
            .rdata_old (id_rdata_old[p*DATA_W +: DATA_W]),
            .fwd_wen   (fwd_wen),
            .fwd_waddr (fwd_waddr),
            .fwd_wdata (fwd_wdata),
            .rdata     (id_rdata[p*DATA_W +: DATA_W])
        );
    end

    // Register zero has no counter, so its busy bit is tied low.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = |cnt_q[r];
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            if (busy[id_raddr[p*ADDR_W +: ADDR_W]]) begin
                stall = id_valid;
            end
        end
    end

    assign issue = id_valid & ~stall & ~pipe_hold & id_wen &
                   (id_waddr != ADDR_W'(REG_ZERO)) & (id_lat != '0);

    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (issue && id_waddr == ADDR_W'(r)) begin
                cnt_d[r] = id_lat;
            end else if (busy[r] && !pipe_hold) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles_q <= '0;
        end else if (stall && stall_cycles_q != '1) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
